// File: rtl/alu_pkg.sv
// Shared opcode and status-flag definitions for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_PASS_B = 3'b001;
    localparam logic [2:0] OP_NEG_A  = 3'b010;
    localparam logic [2:0] OP_NEG_B  = 3'b011;
    localparam logic [2:0] OP_CMP    = 3'b100;
    localparam logic [2:0] OP_XOR    = 3'b101;
    localparam logic [2:0] OP_ADD    = 3'b110;
    localparam logic [2:0] OP_SUB    = 3'b111;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode decode, result and {ovf, carry, neg, zero} flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       fxn_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             ge_signed;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    flags_t           flags;

    // The extra top bit of diff_ext is the unsigned borrow (A < B).
    assign sum_ext   = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext  = {1'b0, a_i} - {1'b0, b_i};
    assign ge_signed = ($signed(a_i) >= $signed(b_i));

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (fxn_i)
            OP_PASS_A: result = a_i;
            OP_PASS_B: result = b_i;
            OP_NEG_A: begin
                result = '0 - a_i;
                ovf    = (a_i == MIN_NEG);
            end
            OP_NEG_B: begin
                result = '0 - b_i;
                ovf    = (b_i == MIN_NEG);
            end
            OP_CMP:    result = {{(WIDTH-1){1'b0}}, ge_signed};
            OP_XOR:    result = a_i ^ b_i;
            OP_ADD: begin
                result = sum_ext[WIDTH-1:0];
                carry  = sum_ext[WIDTH];
                ovf    = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff_ext[WIDTH-1:0];
                carry  = diff_ext[WIDTH];
                ovf    = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                         (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags            = '0;
        flags[FLG_ZERO]  = (result == '0);
        flags[FLG_NEG]   = result[WIDTH-1];
        flags[FLG_CARRY] = carry;
        flags[FLG_OVF]   = ovf;
    end

    assign result_o = result;
    assign flags_o  = flags;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with accumulator feedback.
// S1 holds the accepted operand beat; S2 holds the registered result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_fxn,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc_value
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_fxn_q, s1_fxn_d;
    logic             s1_use_acc_q, s1_use_acc_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_x_q, out_x_d;
    flags_t           out_flags_q, out_flags_d;

    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] core_result;
    flags_t           core_flags;

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    // acc_q already holds the previous beat's result when this beat computes,
    // so chained use_acc beats need no bubble.
    assign eff_a = s1_use_acc_q ? acc_q : s1_a_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (eff_a),
        .b_i      (s1_b_q),
        .fxn_i    (s1_fxn_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_fxn_d     = s1_fxn_q;
        s1_use_acc_d = s1_use_acc_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_a_d       = in_a;
            s1_b_d       = in_b;
            s1_fxn_d     = in_fxn;
            s1_use_acc_d = in_use_acc;
        end else if (s2_load) begin
            s1_valid_d   = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_flags_d = out_flags_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_x_d     = core_result;
            out_flags_d = core_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle load; that result still goes out on out_x.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (s2_load) begin
            acc_d = core_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_fxn_q     <= OP_PASS_A;
            s1_use_acc_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_flags_q  <= '0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_fxn_q     <= s1_fxn_d;
            s1_use_acc_q <= s1_use_acc_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_flags_q  <= out_flags_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_flags = out_flags_q;
    assign acc_value = acc_q;

endmodule
